// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit. Owns the PC, issues one read at a time
// to instruction memory, buffers returned words in a small prefetch queue and
// hands them to the IR. Branch redirects flush the queue and drop any
// response that is still in flight.
// Optional build macro IF_PERF_CNT_EN adds the stall_cnt output, a saturating
// count of cycles where decode was ready but no instruction was available.
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       NOP_INST = 16'h4300
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  input  logic              ir_ready,
  output logic              ir_wen,
  output logic [15:0]       ir_inst,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       queue [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              unused_br_bit;

  // Instructions are always halfword aligned, so the low target bit is dropped.
  assign unused_br_bit = br_target[0];

  assign q_empty = (count == '0);
  assign ir_wen  = ir_ready && !q_empty && !br_taken;
  assign ir_inst = q_empty ? NOP_INST : queue[head];
  assign pop     = ir_wen;
  assign push    = (state == WAIT) && mem_rvalid && !br_taken;

  // Fetch FSM: owns the PC and the registered request pulse; a branch always wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      mem_req <= 1'b0;
      if (br_taken) begin
        pc <= {br_target[ADDR_W-1:1], 1'b0};
        case (state)
          WAIT:    state <= mem_rvalid ? IDLE : DISCARD;
          DISCARD: state <= mem_rvalid ? IDLE : DISCARD;
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (count < DEPTH_C) begin
              state    <= WAIT;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end
          end
          WAIT: begin
            if (mem_rvalid) begin
              state <= IDLE;
              pc    <= pc + PC_STEP;
            end
          end
          DISCARD: begin
            if (mem_rvalid) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Prefetch queue bookkeeping: a branch flushes, push and pop may coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (br_taken) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: data needs no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      queue[tail] <= mem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Stall counter: decode wanted an instruction but the queue was empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= 16'h0000;
    end else if (ir_ready && q_empty && !br_taken && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  // A response can only arrive while a request is outstanding.
  rvalid_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!resetn) !((state == IDLE) && mem_rvalid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch. A directed vector table
// covers the first fetches after reset, hand-written sequences cover queue
// full, branch redirects and reset during a read, and randomized traffic is
// compared every cycle against a transaction-level queue model.
module tb_inst_fetch;

  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_INST = 16'h4300;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        ir_ready = 1'b0;
  logic        ir_wen;
  logic [15:0] ir_inst;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0;
`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  inst_fetch #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ir_ready   (ir_ready),
    .ir_wen     (ir_wen),
    .ir_inst    (ir_inst),
    .br_taken   (br_taken),
    .br_target  (br_target)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pc, a queue of buffered words, and flags for an
  // outstanding read and whether its answer must be thrown away.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  bit          m_out;
  bit          m_drop;
  bit          m_req;
  logic [15:0] m_addr;
  logic [15:0] m_stall;

  // Memory responder: answers each request after lat cycles with addr|A000.
  bit          r_pend;
  int          r_due;
  logic [15:0] r_data;
  int          lat;
  int          cyc;

  // Observed outputs of the most recent cycle.
  logic        obs_req;
  logic [15:0] obs_addr;
  logic        obs_wen;
  logic [15:0] obs_inst;
  int          obs_cyc;

  typedef struct {
    bit          rv;
    logic [15:0] rd;
    bit          rdy;
    bit          exp_req;
    logic [15:0] exp_addr;
    bit          exp_wen;
    logic [15:0] exp_inst;
  } vec_t;

  vec_t        vecs[10];
  int          n;
  int          seen;
  bit          got_addr;
  bit          got_inst;
  logic [15:0] first_addr;
  logic [15:0] first_inst;
  logic [15:0] insts[$];
  int          wen_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelInit();
    m_pc = RESET_PC;
    m_q.delete();
    m_out = 1'b0;
    m_drop = 1'b0;
    m_req = 1'b0;
    m_addr = RESET_PC;
    m_stall = 16'h0;
    r_pend = 1'b0;
    cyc = 0;
  endtask

  task automatic modelEdge(input bit ready, input bit br, input logic [15:0] tgt,
                           input bit rv, input logic [15:0] rd, input bit wen);
    int cnt;
    bit nreq;
    cnt = m_q.size();
    nreq = 1'b0;
    if (ready && cnt == 0 && !br && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (br) begin
      m_q.delete();
      m_pc = {tgt[15:1], 1'b0};
      if (m_out) begin
        if (rv) begin
          m_out = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (m_out) begin
        if (rv) begin
          if (!m_drop) begin
            m_q.push_back(rd);
            m_pc = m_pc + 16'd2;
          end
          m_out = 1'b0;
          m_drop = 1'b0;
        end
      end else if (cnt < DEPTH) begin
        nreq = 1'b1;
        m_addr = m_pc;
        m_out = 1'b1;
      end
      if (wen) void'(m_q.pop_front());
    end
    m_req = nreq;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic applyStimulus(input bit ready, input bit br, input logic [15:0] tgt);
    bit          exp_wen;
    logic [15:0] exp_inst;
    ir_ready = ready;
    br_taken = br;
    br_target = tgt;
    mem_rvalid = r_pend && (cyc == r_due);
    mem_rdata = mem_rvalid ? r_data : 16'($urandom);
    @(negedge clk);
    obs_req = mem_req;
    obs_addr = mem_addr;
    obs_wen = ir_wen;
    obs_inst = ir_inst;
    obs_cyc = cyc;
    exp_wen = ready && (m_q.size() != 0) && !br;
    exp_inst = (m_q.size() != 0) ? m_q[0] : NOP_INST;
    checkOutput("mem_req", 32'(obs_req), 32'(m_req));
    if (m_req) checkOutput("mem_addr", 32'(obs_addr), 32'(m_addr));
    checkOutput("ir_wen", 32'(obs_wen), 32'(exp_wen));
    checkOutput("ir_inst", 32'(obs_inst), 32'(exp_inst));
`ifdef IF_PERF_CNT_EN
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (mem_rvalid) r_pend = 1'b0;
    if (obs_req) begin
      r_pend = 1'b1;
      r_due = cyc + lat;
      r_data = obs_addr | 16'hA000;
    end
    modelEdge(ready, br, tgt, mem_rvalid, mem_rdata, exp_wen);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    ir_ready = 1'b0;
    br_taken = 1'b0;
    br_target = 16'h0;
    mem_rvalid = 1'b0;
    mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    modelInit();
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4300};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h4300};
    vecs[2] = '{1'b1, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4300};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hA000};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h4300};
    vecs[5] = '{1'b1, 16'hA002, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4300};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hA002};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h4300};
    vecs[8] = '{1'b1, 16'hA004, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4300};
    vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hA004};
    lat = 1;
    modelInit();

    // Reset values while reset is held and decode is asking.
    resetn = 1'b0;
    ir_ready = 1'b1;
    #12;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
    checkOutput("rst_ir_wen", 32'(ir_wen), 32'd0);
    checkOutput("rst_ir_inst", 32'(ir_inst), 32'(NOP_INST));

    // Directed table: first three fetches with a 1-cycle memory.
    doReset();
    for (int i = 0; i < 10; i++) begin
      mem_rvalid = vecs[i].rv;
      mem_rdata = vecs[i].rd;
      ir_ready = vecs[i].rdy;
      br_taken = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_req", i), 32'(mem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) checkOutput($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("tbl%0d_wen", i), 32'(ir_wen), 32'(vecs[i].exp_wen));
      checkOutput($sformatf("tbl%0d_inst", i), 32'(ir_inst), 32'(vecs[i].exp_inst));
      @(posedge clk);
      #1;
    end

    // Decode stalled: queue fills after two requests, then drains back-to-back.
    doReset();
    lat = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (obs_req) n++;
    end
    checkOutput("full_req_count", 32'(n), 32'd2);
    insts.delete();
    wen_cyc.delete();
    got_addr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      if (obs_wen) begin
        insts.push_back(obs_inst);
        wen_cyc.push_back(obs_cyc);
      end
      if (obs_req && !got_addr) begin
        got_addr = 1'b1;
        first_addr = obs_addr;
      end
    end
    checkOutput("drain_count_ge2", 32'(insts.size() >= 2), 32'd1);
    if (insts.size() >= 2) begin
      checkOutput("drain_first", 32'(insts[0]), 32'h0000A000);
      checkOutput("drain_second", 32'(insts[1]), 32'h0000A002);
      checkOutput("drain_back_to_back", 32'(wen_cyc[1] - wen_cyc[0]), 32'd1);
    end
    checkOutput("resume_req_seen", 32'(got_addr), 32'd1);
    if (got_addr) checkOutput("resume_addr", 32'(first_addr), 32'h00000004);

    // Branch while a 3-cycle read is pending with one word queued.
    doReset();
    lat = 3;
    seen = 0;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (obs_req) seen++;
    end
    checkOutput("brw_setup_reqs", 32'(seen), 32'd2);
    applyStimulus(1'b1, 1'b1, 16'h0101);
    checkOutput("brw_no_wen_in_br", 32'(obs_wen), 32'd0);
    got_addr = 1'b0;
    got_inst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      if (obs_req && !got_addr) begin
        got_addr = 1'b1;
        first_addr = obs_addr;
      end
      if (obs_wen && !got_inst) begin
        got_inst = 1'b1;
        first_inst = obs_inst;
      end
    end
    checkOutput("brw_req_seen", 32'(got_addr), 32'd1);
    if (got_addr) checkOutput("brw_target_addr", 32'(first_addr), 32'h00000100);
    checkOutput("brw_inst_seen", 32'(got_inst), 32'd1);
    if (got_inst) checkOutput("brw_first_inst", 32'(first_inst), 32'h0000A100);

    // Branch in the same cycle as the response: word dropped, refetch after one idle cycle.
    doReset();
    lat = 1;
    seen = 0;
    for (int i = 0; i < 10 && seen < 1; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (obs_req) seen++;
    end
    checkOutput("brv_setup_req", 32'(seen), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h2468);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("brv_idle_gap_req", 32'(obs_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("brv_target_req", 32'(obs_req), 32'd1);
    checkOutput("brv_target_addr", 32'(obs_addr), 32'h00002468);
    got_inst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      if (obs_wen && !got_inst) begin
        got_inst = 1'b1;
        first_inst = obs_inst;
      end
    end
    checkOutput("brv_inst_seen", 32'(got_inst), 32'd1);
    if (got_inst) checkOutput("brv_first_inst", 32'(first_inst), 32'h0000A468);

    // Reset while a read is outstanding and one word is queued.
    doReset();
    lat = 3;
    seen = 0;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (obs_req) seen++;
    end
    checkOutput("rstw_setup_reqs", 32'(seen), 32'd2);
    ir_ready = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rstw_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rstw_mem_addr", 32'(mem_addr), 32'(RESET_PC));
    checkOutput("rstw_ir_wen", 32'(ir_wen), 32'd0);
    checkOutput("rstw_ir_inst", 32'(ir_inst), 32'(NOP_INST));
    mem_rvalid = 1'b1;
    mem_rdata = 16'hBEEF;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    modelInit();
    got_addr = 1'b0;
    got_inst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      if (obs_req && !got_addr) begin
        got_addr = 1'b1;
        first_addr = obs_addr;
      end
      if (obs_wen && !got_inst) begin
        got_inst = 1'b1;
        first_inst = obs_inst;
      end
    end
    checkOutput("rstw_req_seen", 32'(got_addr), 32'd1);
    if (got_addr) checkOutput("rstw_first_addr", 32'(first_addr), 32'(RESET_PC));
    checkOutput("rstw_inst_seen", 32'(got_inst), 32'd1);
    if (got_inst) checkOutput("rstw_first_inst", 32'(first_inst), 32'(RESET_PC | 16'hA000));

    // Randomized traffic against the reference model.
    for (int seg = 0; seg < 4; seg++) begin
      doReset();
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 250; i++) begin
        applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 16'($urandom));
      end
    end

`ifdef IF_PERF_CNT_EN
    // Stall counter under a 4-cycle memory, then saturation.
    doReset();
    lat = 4;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    force dut.stall_cnt = 16'hFFFF;
    #1;
    release dut.stall_cnt;
    m_stall = 16'hFFFF;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("stall_saturated", 32'(stall_cnt), 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
